btn_mode_ctrl: RTL

BTN_MODE_CTRL -- requirements
Module: btn_mode_ctrl

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_chan.sv | 146 ++++++++++++++
 rtl/btn_mode_ctrl.sv | 40 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the button mode controller.
package btn_pkg;

    // Per-channel debounce/press state machine.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } chan_state_e;

    // Per-channel mode encodings.
    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    // Default parameter values.
    localparam int DEF_NCH         = 4;
    localparam int DEF_DB_CYCLES   = 16;
    localparam int DEF_LONG_CYCLES = 1000;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, debounce, press FSM, hold counter,
// and toggle/momentary enable logic. The FSM state is exported for debug.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_in,
    input  logic        mode,
    output logic        en,
    output logic        press_pulse,
    output logic        long_pulse,
    output chan_state_e state
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic sync_meta;
    logic sync;
    logic stable;
    logic [DB_W-1:0] db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    chan_state_e state_next;
    logic accept;
    logic flip;
    logic rise;
    logic fall;
    logic holding;
    logic long_hit;

    // flip: the debounced level changes on this edge.
    assign flip = (sync != stable) && (db_cnt == DB_LAST);
    assign rise = flip && sync;
    assign fall = flip && !sync;
    assign holding = (state == HELD) || (state == REL_DB);
    assign long_hit = holding && (hold_cnt == HOLD_LAST);

    // Two-flop synchroniser for the raw asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync <= sync_meta;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip the stable level at DB_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    // Next-state logic. With DB_CYCLES = 1 acceptance can coincide with the
    // first synchronised sample, so IDLE/HELD may jump straight across.
    always_comb begin
        state_next = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HELD;
                    accept = 1'b1;
                end else if (sync) begin
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (rise) begin
                    state_next = HELD;
                    accept = 1'b1;
                end else if (!sync) begin
                    state_next = IDLE;
                end
            end
            HELD: begin
                if (fall) state_next = IDLE;
                else if (!sync) state_next = REL_DB;
            end
            REL_DB: begin
                if (fall) state_next = IDLE;
                else if (sync) state_next = HELD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold counter: cleared at press start/acceptance, saturates at LONG_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (accept || (state_next == PRESS_DB && state != PRESS_DB)) begin
            hold_cnt <= '0;
        end else if (holding && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            press_pulse <= accept;
            long_pulse <= long_hit;
        end
    end

    // Enable: follows the hold state when momentary; toggles on press, cleared by long press otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= 1'b0;
        end else if (mode == MODE_MOMENTARY) begin
            en <= holding;
        end else if (long_pulse) begin
            en <= 1'b0;
        end else if (press_pulse) begin
            en <= ~en;
        end
    end

endmodule

// File: rtl/btn_mode_ctrl.sv
// Multi-channel button controller: NCH independent btn_chan instances.
// chan_state carries each channel's FSM state (2 bits per channel) for debug.
module btn_mode_ctrl
    import btn_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   btn_in,
    input  logic [NCH-1:0]   mode,
    output logic [NCH-1:0]   en,
    output logic [NCH-1:0]   press_pulse,
    output logic [NCH-1:0]   long_pulse,
    output logic [2*NCH-1:0] chan_state
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        chan_state_e st;

        btn_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_in     (btn_in[i]),
            .mode       (mode[i]),
            .en         (en[i]),
            .press_pulse(press_pulse[i]),
            .long_pulse (long_pulse[i]),
            .state      (st)
        );

        assign chan_state[2*i +: 2] = st;
    end

endmodule
